axis_pkt_buffer: RTL and testbench
==================================

# axis_pkt_buffer

Store-and-forward AXI-Stream packet buffer: once armed by `enable`, it captures one packet from an upstream AXI-Stream slave port into on-chip memory. It then replays that packet `REPLAY_COUNT` times on an AXI-Stream master port, honouring backpressure. It generalises the existing single-stream memory wrapper with the following:
- a real upstream data path
- parametrised depth, width and replay count
- overflow handling
- full-throughput drain
All logic runs in one clock domain.

## Interface
- `DATA_WIDTH`, 32, tdata width in bits; must be a multiple of 8
- `ADDR_WIDTH`, 12, memory address width
- `MEM_SIZE`, 4096, buffer depth in beats; must satisfy MEM_SIZE ≤ 2**ADDR_WIDTH
- `REPLAY_COUNT`, 1, number of times each captured packet is emitted; range 1..255
---
- `axis_aclk`  in  1  clock
- `axis_aresetn`  in  1  asynchronous active-low reset
- `enable`  in  1  arms one capture; sampled only in IDLE
- `s_axis_tdata`  in  DATA_WIDTH  upstream data
- `s_axis_tstrb`  in  DATA_WIDTH/8  upstream byte strobes
- `s_axis_tvalid`  in  1  upstream valid
- `s_axis_tlast`  in  1  upstream end of packet
- `s_axis_tready`  out  1  high only in FILL
- `m_axis_tdata`  out  DATA_WIDTH  downstream data
- `m_axis_tstrb`  out  DATA_WIDTH/8  downstream strobes
- `m_axis_tvalid`  out  1  downstream valid
- `m_axis_tlast`  out  1  last beat of each replay
- `m_axis_tready`  in  1  downstream ready
- `pkt_len`  out  ADDR_WIDTH+1  beats captured in the last packet
- `busy`  out  1  high in FILL or DRAIN
- `overflow`  out  1  sticky; the last capture was truncated at MEM_SIZE

## Operation
- States: IDLE, FILL, DRAIN.
- **IDLE**
  - `enable`=1 → FILL on the next edge.
  - At the transition, clear the write pointer, `pkt_len` and `overflow`.
- **FILL**
  - `s_axis_tready`=1.
  - Each beat with `s_axis_tvalid`=1 is written with its data and strobes at the write pointer; the pointer then increments.
  - Exit to DRAIN on the accepted beat with `tlast`=1, or on the accepted MEM_SIZE-th beat.
  - On the MEM_SIZE-th beat without `tlast`: set `overflow`=1 and treat that beat as last.
  - Upstream beats after truncation are not accepted (`s_axis_tready`=0).
- **DRAIN**
  - Read beats 0..`pkt_len`-1 in order, repeated `REPLAY_COUNT` times.
  - `m_axis_tlast`=1 on beat `pkt_len`-1 of every replay.
  - After the final beat of the final replay is accepted → IDLE.
- `pkt_len` updates on the FILL→DRAIN edge and holds until the next arm.
- `enable` is ignored outside IDLE.

## Timing
- Every output resets to 0 and the state resets to IDLE. Reset takes effect asynchronously, including mid-FILL or mid-DRAIN. Memory contents are don't-care after reset.
- Memory has synchronous read with 1-cycle latency. A 2-entry prefetch/skid stage drives the master outputs.
- First `m_axis_tvalid` is high 2 cycles after the FILL→DRAIN edge.
- With `m_axis_tready` held high: one beat per cycle, with no bubbles between replays.
- Master handshake rules:
  - Once `m_axis_tvalid` is high, `tdata`, `tstrb` and `tlast` stay stable until `m_axis_tready`=1.
  - `m_axis_tvalid` never drops without a handshake.
- `busy` is high from the cycle after `enable` is sampled until the cycle after the final handshake.
- A single-beat packet (`tlast` on the first beat) is legal; every replay is then one beat with `tlast`=1.
- Replay counter is 8 bits; the read pointer wraps to 0 at `pkt_len`.

## Configuration
- `AXIS_PKT_BUF_TSTRB_EN` defined:
  - strobes are stored per beat, making the memory DATA_WIDTH+DATA_WIDTH/8 wide;
  - `m_axis_tstrb` replays the captured strobes.
- Undefined:
  - strobes are not stored and `s_axis_tstrb` is ignored;
  - `m_axis_tstrb` is all-ones whenever `m_axis_tvalid`=1, and 0 otherwise.

## Structure
- Package `axis_pkt_buf_pkg`:
  - state enum typedef (IDLE/FILL/DRAIN);
  - constant `REPLAY_W`=8;
  - function deriving the strobe width from DATA_WIDTH.
- Sub-module `axis_pkt_buf_ram`: simple dual-port RAM with 1 write port and 1 synchronous read port, parametrised width/depth.
- The top level holds the FSM, pointers, replay counter and output skid stage.

## Test plan
- **Basic loopback:** reset, `enable` pulse, 8 beats with data 0x100..0x107 and `tlast` on beat 8, `m_axis_tready`=1 → 8 beats 0x100..0x107 out; `tlast` only on 0x107; `pkt_len`=8; `busy` low after.
- **Replay with backpressure:** REPLAY_COUNT=3, 4-beat packet, `m_axis_tready` toggling 1,0,0,1 → 12 beats in order, `tlast` on beats 4/8/12, outputs stable during every stall.
- **Overflow:** MEM_SIZE=16, send 20 beats with no `tlast` → 16 accepted, `overflow`=1, `pkt_len`=16; beat 16 emitted with `tlast`; beats 17–20 see `s_axis_tready`=0.
- **Single beat:** 1 beat 0xDEADBEEF with `tlast` → one output beat with `tlast`=1, first `tvalid` 2 cycles after the capture.
- **Reset mid-DRAIN:** assert `axis_aresetn`=0 after 3 of 8 output beats → all outputs 0 immediately and state IDLE; re-arm and capture a new packet correctly.
- **Strobe path:** with `AXIS_PKT_BUF_TSTRB_EN`, input strobes 0xF, 0x3, 0x1 are replayed identically; without it, output is always 0xF.

Source files
------------

// File: rtl/axis_pkt_buf_pkg.sv
// rtl/axis_pkt_buf_pkg.sv - shared state encoding, replay counter width and strobe width helper
package axis_pkt_buf_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FILL  = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_FILL  = S_FILL,
      ST_DRAIN = S_DRAIN
   } pkt_state_e;

   localparam int REPLAY_W = 8;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/axis_pkt_buf_ram.sv
// rtl/axis_pkt_buf_ram.sv - simple dual-port RAM, one write port and one registered read port
module axis_pkt_buf_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4096,
   parameter int AW    = 12
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/axis_pkt_buffer.sv
// rtl/axis_pkt_buffer.sv - store-and-forward AXI-Stream packet buffer with replay
// Optional AXIS_PKT_BUF_TSTRB_EN stores and replays per-beat strobes.
module axis_pkt_buffer
   import axis_pkt_buf_pkg::*;
#(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 12,
   parameter int MEM_SIZE     = 4096,
   parameter int REPLAY_COUNT = 1
) (
   input  logic                    axis_aclk,
   input  logic                    axis_aresetn,
   input  logic                    enable,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [DATA_WIDTH/8-1:0] s_axis_tstrb,
   input  logic                    s_axis_tvalid,
   input  logic                    s_axis_tlast,
   output logic                    s_axis_tready,
   output logic [DATA_WIDTH-1:0]   m_axis_tdata,
   output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
   output logic                    m_axis_tvalid,
   output logic                    m_axis_tlast,
   input  logic                    m_axis_tready,
   output logic [ADDR_WIDTH:0]     pkt_len,
   output logic                    busy,
   output logic                    overflow
);

   localparam int SW = strb_width(DATA_WIDTH);
   localparam int CW = ADDR_WIDTH + 1;
`ifdef AXIS_PKT_BUF_TSTRB_EN
   localparam int MW = DATA_WIDTH + SW;
`else
   localparam int MW = DATA_WIDTH;
`endif

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [REPLAY_W-1:0]   rep_cnt;
   logic                  issue_done;
   logic                  rd_vld, rd_last, rd_final;
   logic [MW-1:0]         ram_wdata, ram_rdata;

   logic [MW-1:0] sk_data [2];
   logic [1:0]    sk_last, sk_final;
   logic          sk_head, sk_tail;
   logic [1:0]    sk_cnt;

   logic accept, pop, issue, issue_last, rep_last;

   assign s_axis_tready = (state == S_FILL);
   assign busy          = (state != S_IDLE);
   assign accept        = s_axis_tready && s_axis_tvalid;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign issue_last    = ({1'b0, rd_ptr} == pkt_len - CW'(1));
   assign rep_last      = (rep_cnt == REPLAY_W'(REPLAY_COUNT - 1));

   // Reads in flight plus skid occupancy never exceed two once this cycle's pop is credited.
   assign issue = (state == S_DRAIN) && !issue_done &&
                  (({1'b0, sk_cnt} + {2'b00, rd_vld}) < (3'd2 + {2'b00, pop}));

`ifdef AXIS_PKT_BUF_TSTRB_EN
   assign ram_wdata = {s_axis_tstrb, s_axis_tdata};
`else
   logic unused_strb;
   assign unused_strb = ^s_axis_tstrb;
   assign ram_wdata   = s_axis_tdata;
`endif

   axis_pkt_buf_ram #(
      .WIDTH (MW),
      .DEPTH (MEM_SIZE),
      .AW    (ADDR_WIDTH)
   ) u_ram (
      .clk   (axis_aclk),
      .we    (accept),
      .waddr (wr_ptr),
      .wdata (ram_wdata),
      .re    (issue),
      .raddr (rd_ptr),
      .rdata (ram_rdata)
   );

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         state      <= S_IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         rep_cnt    <= '0;
         issue_done <= 1'b0;
         pkt_len    <= '0;
         overflow   <= 1'b0;
         rd_vld     <= 1'b0;
         rd_last    <= 1'b0;
         rd_final   <= 1'b0;
      end else begin
         rd_vld   <= issue;
         rd_last  <= issue_last;
         rd_final <= issue_last && rep_last;
         case (state)
            S_IDLE: begin
               if (enable) begin
                  state    <= S_FILL;
                  wr_ptr   <= '0;
                  pkt_len  <= '0;
                  overflow <= 1'b0;
               end
            end
            S_FILL: begin
               if (accept) begin
                  wr_ptr <= wr_ptr + 1'b1;
                  if (s_axis_tlast || ({1'b0, wr_ptr} == CW'(MEM_SIZE - 1))) begin
                     state      <= S_DRAIN;
                     pkt_len    <= {1'b0, wr_ptr} + CW'(1);
                     overflow   <= !s_axis_tlast;
                     rd_ptr     <= '0;
                     rep_cnt    <= '0;
                     issue_done <= 1'b0;
                  end
               end
            end
            S_DRAIN: begin
               if (issue) begin
                  if (issue_last) begin
                     rd_ptr <= '0;
                     if (rep_last) issue_done <= 1'b1;
                     else          rep_cnt    <= rep_cnt + 1'b1;
                  end else begin
                     rd_ptr <= rd_ptr + 1'b1;
                  end
               end
               if (pop && sk_final[sk_head]) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         sk_cnt   <= '0;
         sk_head  <= 1'b0;
         sk_tail  <= 1'b0;
         sk_last  <= '0;
         sk_final <= '0;
      end else begin
         if (rd_vld) begin
            sk_last[sk_tail]  <= rd_last;
            sk_final[sk_tail] <= rd_final;
            sk_tail           <= ~sk_tail;
         end
         if (pop) sk_head <= ~sk_head;
         sk_cnt <= sk_cnt + {1'b0, rd_vld} - {1'b0, pop};
      end
   end

   always_ff @(posedge axis_aclk) begin
      if (rd_vld) sk_data[sk_tail] <= ram_rdata;
   end

   // Payload is gated so every master output reads 0 while nothing is presented.
   assign m_axis_tvalid = (sk_cnt != 2'd0);
   assign m_axis_tdata  = m_axis_tvalid ? sk_data[sk_head][DATA_WIDTH-1:0] : '0;
   assign m_axis_tlast  = m_axis_tvalid && sk_last[sk_head];
`ifdef AXIS_PKT_BUF_TSTRB_EN
   assign m_axis_tstrb  = m_axis_tvalid ? sk_data[sk_head][MW-1:DATA_WIDTH] : '0;
`else
   assign m_axis_tstrb  = {SW{m_axis_tvalid}};
`endif

endmodule

// File: tb/tb_axis_pkt_buffer.sv
// tb/tb_axis_pkt_buffer.sv - scoreboard bench for axis_pkt_buffer (REPLAY_COUNT=3, MEM_SIZE=16)
module tb_axis_pkt_buffer;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int MS = 16;
   localparam int RC = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic [DW-1:0] s_tdata = '0;
   logic [3:0]    s_tstrb = '0;
   logic          s_tvalid = 1'b0;
   logic          s_tlast = 1'b0;
   logic          s_tready;
   logic [DW-1:0] m_tdata;
   logic [3:0]    m_tstrb;
   logic          m_tvalid;
   logic          m_tlast;
   logic          m_tready = 1'b1;
   logic [AW:0]   pkt_len;
   logic          busy;
   logic          overflow;

   axis_pkt_buffer #(
      .DATA_WIDTH   (DW),
      .ADDR_WIDTH   (AW),
      .MEM_SIZE     (MS),
      .REPLAY_COUNT (RC)
   ) dut (
      .axis_aclk     (clk),
      .axis_aresetn  (rst_n),
      .enable        (enable),
      .s_axis_tdata  (s_tdata),
      .s_axis_tstrb  (s_tstrb),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tlast  (s_tlast),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tstrb  (m_tstrb),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tlast  (m_tlast),
      .m_axis_tready (m_tready),
      .pkt_len       (pkt_len),
      .busy          (busy),
      .overflow      (overflow)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [3:0]    s;
      logic          l;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] pd[MS];
   logic [3:0]    ps[MS];
   int            n_pass = 0;
   int            n_total = 0;
   int            out_cnt = 0;
   logic          bp_mode = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic expect_pkt(input int n);
      exp_t e;
      for (int r = 0; r < RC; r++) begin
         for (int i = 0; i < n; i++) begin
            e.d = pd[i];
`ifdef AXIS_PKT_BUF_TSTRB_EN
            e.s = ps[i];
`else
            e.s = 4'hF;
`endif
            e.l = (i == n - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   task automatic arm();
      @(posedge clk); #1;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic [3:0] s, input logic l);
      int n;
      n = 0;
      s_tvalid = 1'b1; s_tdata = d; s_tstrb = s; s_tlast = l;
      @(negedge clk);
      while (!s_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!s_tready) begin
         n_total++;
         $display("FAIL send_timeout: tready 0 expected 1");
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_pkt(input int n, input logic with_last);
      for (int i = 0; i < n; i++) send_beat(pd[i], ps[i], with_last && (i == n - 1));
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check({name, "_busy_low"}, 64'(busy), 64'd0);
      check({name, "_all_beats_out"}, 64'(exp_q.size()), 64'd0);
   endtask

   // Monitor: pops expected beats on each handshake and holds stalled beats for stability checks.
   initial begin
      exp_t e;
      logic hold;
      logic [DW+5:0] hold_val;
      hold = 1'b0;
      hold_val = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) check("stall_stable", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'(hold_val));
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  n_total++;
                  $display("FAIL unexpected_beat: got %0h expected none", m_tdata);
               end else begin
                  e = exp_q.pop_front();
                  check("out_data", 64'(m_tdata), 64'(e.d));
                  check("out_strb", 64'(m_tstrb), 64'(e.s));
                  check("out_last", 64'(m_tlast), 64'(e.l));
               end
               out_cnt++;
               hold = 1'b0;
            end else if (m_tvalid) begin
               hold = 1'b1;
               hold_val = {m_tvalid, m_tlast, m_tstrb, m_tdata};
            end else begin
               hold = 1'b0;
            end
         end
      end
   end

   initial begin
      int k;
      k = 0;
      forever begin
         @(posedge clk); #1;
         if (bp_mode) begin
            m_tready = (k % 4 == 0) || (k % 4 == 3);
            k++;
         end else begin
            m_tready = 1'b1;
         end
      end
   end

   initial begin
      int n;
      int base;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", 64'(m_tvalid), 64'd0);
      check("rst_tready", 64'(s_tready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pkt_len", 64'(pkt_len), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // basic loopback
      for (int i = 0; i < 8; i++) begin pd[i] = 32'h100 + i; ps[i] = 4'hF; end
      arm();
      check("fill_busy", 64'(busy), 64'd1);
      expect_pkt(8);
      send_pkt(8, 1'b1);
      wait_idle("basic");
      check("basic_pkt_len", 64'(pkt_len), 64'd8);
      check("basic_overflow", 64'(overflow), 64'd0);

      // replay with backpressure
      for (int i = 0; i < 4; i++) begin pd[i] = 32'h200 + i; ps[i] = 4'hF; end
      bp_mode = 1'b1;
      arm();
      expect_pkt(4);
      send_pkt(4, 1'b1);
      wait_idle("bp");
      bp_mode = 1'b0;
      check("bp_pkt_len", 64'(pkt_len), 64'd4);

      // overflow: 16 accepted, beats 17..20 refused
      for (int i = 0; i < MS; i++) begin pd[i] = 32'h300 + i; ps[i] = 4'hF; end
      arm();
      expect_pkt(MS);
      send_pkt(MS, 1'b0);
      for (int i = 16; i < 20; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'h300 + i; s_tlast = 1'b0;
         @(negedge clk);
         check("ovf_refused", 64'(s_tready), 64'd0);
         @(posedge clk); #1;
      end
      s_tvalid = 1'b0;
      check("ovf_flag", 64'(overflow), 64'd1);
      check("ovf_pkt_len", 64'(pkt_len), 64'd16);
      wait_idle("ovf");

      // single beat and first-valid latency
      pd[0] = 32'hDEADBEEF; ps[0] = 4'hF;
      arm();
      check("ovf_cleared_on_arm", 64'(overflow), 64'd0);
      expect_pkt(1);
      send_beat(pd[0], ps[0], 1'b1);
      @(negedge clk);
      @(negedge clk);
      check("single_lat_cycle1", 64'(m_tvalid), 64'd0);
      @(negedge clk);
      check("single_lat_cycle2", 64'(m_tvalid), 64'd1);
      wait_idle("single");
      check("single_pkt_len", 64'(pkt_len), 64'd1);

      // reset mid-DRAIN after three accepted beats
      for (int i = 0; i < 8; i++) begin pd[i] = 32'h500 + i; ps[i] = 4'hF; end
      arm();
      expect_pkt(8);
      base = out_cnt;
      send_pkt(8, 1'b1);
      n = 0;
      while (out_cnt < base + 3 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("mid_drain_reached", 64'(out_cnt - base), 64'd3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("rst_mid_outputs", 64'({m_tvalid, m_tlast, m_tstrb, m_tdata}), 64'd0);
      check("rst_mid_state", 64'({busy, s_tready, overflow}), 64'd0);
      check("rst_mid_pkt_len", 64'(pkt_len), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin pd[i] = 32'h600 + i; ps[i] = 4'hF; end
      arm();
      expect_pkt(3);
      send_pkt(3, 1'b1);
      wait_idle("rearm");
      check("rearm_pkt_len", 64'(pkt_len), 64'd3);

      // strobe path
      pd[0] = 32'h700; ps[0] = 4'hF;
      pd[1] = 32'h701; ps[1] = 4'h3;
      pd[2] = 32'h702; ps[2] = 4'h1;
      arm();
      expect_pkt(3);
      send_pkt(3, 1'b1);
      wait_idle("strb");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: time %0t expected finish earlier", $time);
      $fatal(1);
   end

endmodule
